// File: rtl/clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// clk_freq_monitor
//
// OPB-mapped frequency meter for the divided clocks produced by the clock
// generator. Each monitored clock is synchronized into OPB_CLK, its rising
// edges are counted over a programmable gate window, and the per-channel
// counts are latched for firmware readback. A channel whose count falls below
// a programmable minimum raises a sticky fault flag.
//
// Register map (16-bit registers, zero-extended onto OPB_DO):
//   0x0 CTRL     bit0 EN, bit1 ONESHOT
//   0x1 GATE     window length in OPB_CLK cycles
//   0x2 MIN      fault threshold in edges per window
//   0x3 STATUS   [7:0] SEQ (read-only), [15:8] FAULT (write 1 to clear)
//   0x4 IRQ_MASK (only when CLK_FREQ_MON_IRQ_EN is defined)
//   0x8+n        RESULT[n] (read-only)
//
// Optional feature: define CLK_FREQ_MON_IRQ_EN to add the IRQ output and the
// IRQ_MASK register. Without it, address 0x4 is unused.
//
// Ports:
//   OPB_CLK    bus and measurement clock
//   OPB_RST    asynchronous active-high reset
//   OPB_ADDR   register address
//   OPB_DI     write data
//   OPB_WE     write strobe, one register write per high cycle
//   OPB_RE     read enable
//   OPB_DO     read data, released (z) when not addressed
//   CLK_MON    monitored clocks, asynchronous to OPB_CLK
//   MEAS_DONE  one-cycle pulse when a window's results are latched
//   CLK_FAULT  sticky per-channel fault flags (mirror of STATUS[15:8])
//   IRQ        |(FAULT & IRQ_MASK), registered (optional)
// -----------------------------------------------------------------------------
module clk_freq_monitor #(
  parameter int          NUM_CH    = 4,
  parameter logic [15:0] GATE_DFLT = 16'd4000,
  parameter logic [15:0] MIN_DFLT  = 16'd1
) (
  input  logic              OPB_CLK,
  input  logic              OPB_RST,
  input  logic [3:0]        OPB_ADDR,
  input  logic [15:0]       OPB_DI,
  input  logic              OPB_WE,
  input  logic              OPB_RE,
  output logic [31:0]       OPB_DO,
  input  logic [NUM_CH-1:0] CLK_MON,
  output logic              MEAS_DONE,
  output logic [NUM_CH-1:0] CLK_FAULT
`ifdef CLK_FREQ_MON_IRQ_EN
  ,
  output logic              IRQ
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, LATCH = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic                     ctrl_en_q, ctrl_oneshot_q;
  logic [15:0]              gate_q, min_q, min_win_q, gate_cnt_q;
  logic [7:0]               seq_q;
  logic [NUM_CH-1:0]        fault_q, fault_set, fault_clr;
  logic [NUM_CH-1:0][15:0]  cnt_q, result_q;
  logic [NUM_CH-1:0]        mon_p0, mon_p1, mon_p2, edge_p2;
  logic                     load_win, latch;
  logic [15:0]              rdata;
  logic                     rvalid;

  // ---- stage p0/p1: two-flop synchronizer; p2: delayed copy for edge detect
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      mon_p0 <= '0;
      mon_p1 <= '0;
      mon_p2 <= '0;
    end else begin
      mon_p0 <= CLK_MON;
      mon_p1 <= mon_p0;
      mon_p2 <= mon_p1;
    end
  end

  assign edge_p2 = mon_p1 & ~mon_p2;

  // ---- FSM: state register
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ctrl_en_q && gate_q != 16'd0) state_d = COUNT;
      // Clearing EN aborts the window even on its final cycle.
      COUNT: if (!ctrl_en_q)                   state_d = IDLE;
             else if (gate_cnt_q == 16'd1)     state_d = LATCH;
      LATCH: state_d = (ctrl_en_q && !ctrl_oneshot_q && gate_q != 16'd0) ? COUNT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    latch     = (state_q == LATCH);
    MEAS_DONE = latch;
    load_win  = (state_q != COUNT) && (state_d == COUNT);
  end

  // ---- window timer; MIN is snapshotted so mid-window writes wait a window
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      gate_cnt_q <= '0;
      min_win_q  <= MIN_DFLT;
    end else if (load_win) begin
      gate_cnt_q <= gate_q;
      min_win_q  <= min_q;
    end else if (state_q == COUNT) begin
      gate_cnt_q <= gate_cnt_q - 16'd1;
    end
  end

  // ---- edge counters: only live in COUNT, so LATCH-cycle edges are dropped
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      cnt_q <= '0;
    end else if (state_q != COUNT) begin
      cnt_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++)
        if (edge_p2[n] && cnt_q[n] != 16'hFFFF) cnt_q[n] <= cnt_q[n] + 16'd1;
    end
  end

  always_comb begin
    fault_set = '0;
    fault_clr = '0;
    if (latch)
      for (int n = 0; n < NUM_CH; n++) fault_set[n] = (cnt_q[n] < min_win_q);
    if (OPB_WE && OPB_ADDR == 4'h3) fault_clr = OPB_DI[8 +: NUM_CH];
  end

  // ---- register file and result latch
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      ctrl_en_q      <= 1'b0;
      ctrl_oneshot_q <= 1'b0;
      gate_q         <= GATE_DFLT;
      min_q          <= MIN_DFLT;
      seq_q          <= '0;
      fault_q        <= '0;
      result_q       <= '0;
    end else begin
      // A firmware CTRL write in the LATCH cycle overrides the one-shot clear.
      if (OPB_WE && OPB_ADDR == 4'h0) begin
        ctrl_en_q      <= OPB_DI[0];
        ctrl_oneshot_q <= OPB_DI[1];
      end else if (latch && ctrl_oneshot_q) begin
        ctrl_en_q      <= 1'b0;
      end
      if (OPB_WE && OPB_ADDR == 4'h1) gate_q <= OPB_DI;
      if (OPB_WE && OPB_ADDR == 4'h2) min_q  <= OPB_DI;
      // Set takes priority over a same-cycle clear.
      fault_q <= (fault_q & ~fault_clr) | fault_set;
      if (latch) begin
        result_q <= cnt_q;
        seq_q    <= seq_q + 8'd1;
      end
    end
  end

  assign CLK_FAULT = fault_q;

`ifdef CLK_FREQ_MON_IRQ_EN
  logic [NUM_CH-1:0] irq_mask_q;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      irq_mask_q <= '0;
      IRQ        <= 1'b0;
    end else begin
      if (OPB_WE && OPB_ADDR == 4'h4) irq_mask_q <= OPB_DI[NUM_CH-1:0];
      IRQ <= |(fault_q & irq_mask_q);
    end
  end
`endif

  // ---- read mux
  always_comb begin
    rdata  = 16'h0000;
    rvalid = 1'b0;
    case (OPB_ADDR)
      4'h0: begin rvalid = 1'b1; rdata[1:0] = {ctrl_oneshot_q, ctrl_en_q}; end
      4'h1: begin rvalid = 1'b1; rdata = gate_q; end
      4'h2: begin rvalid = 1'b1; rdata = min_q; end
      4'h3: begin
        rvalid             = 1'b1;
        rdata[7:0]         = seq_q;
        rdata[8 +: NUM_CH] = fault_q;
      end
`ifdef CLK_FREQ_MON_IRQ_EN
      4'h4: begin rvalid = 1'b1; rdata[NUM_CH-1:0] = irq_mask_q; end
`endif
      default: begin
        for (int n = 0; n < NUM_CH; n++)
          if (OPB_ADDR == 4'(8 + n)) begin
            rvalid = 1'b1;
            rdata  = result_q[n];
          end
      end
    endcase
  end

  // Shared bus: drive only when this block owns the addressed register.
  assign OPB_DO = (OPB_RE && rvalid) ? {16'h0000, rdata} : 32'bz;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_freq_monitor
//
// Self-checking bench for clk_freq_monitor. Monitored clocks are generated as
// integer divisions of OPB_CLK (some with random divisors); expected counts
// come from window length / clock period, with +/-1 for phase alignment.
// -----------------------------------------------------------------------------
module tb_clk_freq_monitor;

  localparam int NCH = 4;

  logic            opb_clk = 1'b0;
  logic            opb_rst;
  logic [3:0]      opb_addr;
  logic [15:0]     opb_di;
  logic            opb_we, opb_re;
  wire  [31:0]     opb_do;
  logic [NCH-1:0]  clk_mon;
  wire             meas_done;
  wire  [NCH-1:0]  clk_fault;
`ifdef CLK_FREQ_MON_IRQ_EN
  wire             irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mon_per[NCH];   // period in OPB_CLK cycles, 0 = held low
  int mon_ph[NCH];
  int cyc = 0;
  int done_cnt = 0;
  int done_at[$];
  logic [31:0] rd;
  logic [7:0]  fexp;
  int lat, d0, g;

  always #5 opb_clk = ~opb_clk;

  clk_freq_monitor #(.NUM_CH(NCH)) dut (
    .OPB_CLK   (opb_clk),
    .OPB_RST   (opb_rst),
    .OPB_ADDR  (opb_addr),
    .OPB_DI    (opb_di),
    .OPB_WE    (opb_we),
    .OPB_RE    (opb_re),
    .OPB_DO    (opb_do),
    .CLK_MON   (clk_mon),
    .MEAS_DONE (meas_done),
    .CLK_FAULT (clk_fault)
`ifdef CLK_FREQ_MON_IRQ_EN
    ,
    .IRQ       (irq)
`endif
  );

  always @(posedge opb_clk) cyc++;

  always @(negedge opb_clk) begin
    if (meas_done === 1'b1) begin
      done_cnt++;
      done_at.push_back(cyc);
    end
  end

  // Divided clocks, changed on the falling edge so they are stable at sampling.
  always @(negedge opb_clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (mon_per[c] == 0) begin
        mon_ph[c]  = 0;
        clk_mon[c] = 1'b0;
      end else begin
        mon_ph[c]  = (mon_ph[c] + 1) % mon_per[c];
        clk_mon[c] = (mon_ph[c] < mon_per[c] / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp, input int tol);
    int o, e;
    o = obs;
    e = exp;
    n_cmp++;
    if (o < e - tol || o > e + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, o, e, tol);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge opb_clk);
    opb_addr = a;
    opb_di   = d;
    opb_we   = 1'b1;
    @(negedge opb_clk);
    opb_we   = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge opb_clk);
    opb_addr = a;
    opb_re   = 1'b1;
    #1;
    d = opb_do;
    opb_re = 1'b0;
  endtask

  // Returns the number of falling edges waited until MEAS_DONE, 0 on timeout.
  task automatic wait_done(input int limit, output int l);
    l = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge opb_clk);
      if (meas_done === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    opb_rst = 1'b1;
    repeat (3) @(negedge opb_clk);
    opb_rst = 1'b0;
    done_at.delete();
  endtask

  initial begin
    opb_rst  = 1'b1;
    opb_addr = '0;
    opb_di   = '0;
    opb_we   = 1'b0;
    opb_re   = 1'b0;
    for (int c = 0; c < NCH; c++) mon_per[c] = 0;

    // ---------------- reset values
    do_reset();
    check("rst_done", 32'(meas_done), 0, 0);
    check("rst_fault", 32'(clk_fault), 0, 0);
    opb_addr = 4'h1;
    #1;
    // A released bus reads z in a 4-state simulator and 0 in a 2-state one.
    check("do_idle", (opb_do === 32'bz) ? 32'h0 : opb_do, 0, 0);
    bus_rd(4'h5, rd);
    check("do_unused", (rd === 32'bz) ? 32'h0 : rd, 0, 0);
    bus_rd(4'h0, rd); check("rst_ctrl", rd, 0, 0);
    bus_rd(4'h1, rd); check("rst_gate", rd, 4000, 0);
    bus_rd(4'h2, rd); check("rst_min", rd, 1, 0);
    bus_rd(4'h3, rd); check("rst_status", rd, 0, 0);
    for (int c = 0; c < NCH; c++) begin
      bus_rd(4'(8 + c), rd);
      check($sformatf("rst_result%0d", c), rd, 0, 0);
    end
`ifdef CLK_FREQ_MON_IRQ_EN
    check("rst_irq", 32'(irq), 0, 0);
`endif

    // ---------------- continuous counting
    mon_per[0] = 8;
    mon_per[1] = 40;
    mon_per[2] = $urandom_range(5, 60);
    mon_per[3] = $urandom_range(5, 60);
    bus_wr(4'h1, 16'd800);
    bus_wr(4'h0, 16'h0001);
    for (int w = 1; w <= 3; w++) begin
      wait_done(1000, lat);
      if (w == 1) check("first_lat", lat, 801, 0);
      else        check($sformatf("done_found%0d", w), 32'(lat > 0), 1, 0);
      @(negedge opb_clk);
      check($sformatf("done_1cyc%0d", w), 32'(meas_done), 0, 0);
      for (int c = 0; c < NCH; c++) begin
        bus_rd(4'(8 + c), rd);
        check($sformatf("w%0d_res%0d", w, c), rd, 800 / mon_per[c], 1);
      end
      bus_rd(4'h3, rd);
      check($sformatf("w%0d_seq", w), 32'(rd[7:0]), w, 0);
      check($sformatf("w%0d_fault", w), 32'(rd[15:8]), 0, 0);
      if (w > 1 && done_at.size() >= w)
        check($sformatf("interval%0d", w), done_at[w-1] - done_at[w-2], 801, 0);
    end

    // ---------------- fault detection
    mon_per[2] = 0;
    bus_wr(4'h2, 16'd5);
    wait_done(1000, lat);
    wait_done(1000, lat);
    fexp = '0;
    for (int c = 0; c < NCH; c++) if (mon_per[c] == 0) fexp[c] = 1'b1;
    bus_rd(4'h3, rd);
    check("fault_set", 32'(rd[15:8]), 32'(fexp), 0);
    check("clk_fault_set", 32'(clk_fault), 32'(fexp), 0);
    bus_wr(4'h3, 16'h0400);
    bus_rd(4'h3, rd);
    check("fault_w1c", 32'(rd[15:8]), 0, 0);
    check("clk_fault_w1c", 32'(clk_fault), 0, 0);
    // Land a W1C on the same edge that re-sets the fault.
    lat = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge opb_clk);
      if (meas_done === 1'b1) begin
        lat = i;
        opb_addr = 4'h3;
        opb_di   = 16'h0400;
        opb_we   = 1'b1;
        break;
      end
    end
    @(negedge opb_clk);
    opb_we = 1'b0;
    check("race_found", 32'(lat > 0), 1, 0);
    bus_rd(4'h3, rd);
    check("fault_setwins", 32'(rd[15:8]), 32'(fexp), 0);
    check("clk_fault_setwins", 32'(clk_fault), 32'(fexp), 0);

    // ---------------- reset in the middle of a window
    repeat (100) @(negedge opb_clk);
    opb_rst = 1'b1;
    #1;
    check("arst_fault", 32'(clk_fault), 0, 0);
    repeat (3) @(negedge opb_clk);
    opb_rst = 1'b0;
    done_at.delete();
    d0 = done_cnt;
    bus_rd(4'h0, rd); check("arst_ctrl", rd, 0, 0);
    bus_rd(4'h1, rd); check("arst_gate", rd, 4000, 0);
    bus_rd(4'h3, rd); check("arst_status", rd, 0, 0);
    bus_rd(4'h8, rd); check("arst_result0", rd, 0, 0);
    repeat (900) @(negedge opb_clk);
    check("arst_nodone", done_cnt - d0, 0, 0);

    // ---------------- one-shot
    mon_per[2] = 16;
    bus_wr(4'h1, 16'd100);
    d0 = done_cnt;
    bus_wr(4'h0, 16'h0003);
    wait_done(300, lat);
    check("os_lat", lat, 101, 0);
    repeat (300) @(negedge opb_clk);
    check("os_count", done_cnt - d0, 1, 0);
    bus_rd(4'h0, rd); check("os_ctrl", rd, 2, 0);
    bus_rd(4'h3, rd); check("os_status", rd, 1, 0);
    bus_rd(4'h8, rd); check("os_res0", rd, 100 / 8, 1);
    bus_rd(4'h9, rd); check("os_res1", rd, 100 / 40, 1);

    // ---------------- abort
    bus_wr(4'h1, 16'd400);
    bus_wr(4'h0, 16'h0001);
    repeat (49) @(negedge opb_clk);
    d0 = done_cnt;
    bus_wr(4'h0, 16'h0000);
    repeat (500) @(negedge opb_clk);
    check("abort_nodone", done_cnt - d0, 0, 0);
    bus_rd(4'h8, rd); check("abort_res0", rd, 100 / 8, 1);
    bus_rd(4'h3, rd); check("abort_seq", 32'(rd[7:0]), 1, 0);
    // A fresh window after the abort must take the full GATE+1 from IDLE.
    g = $urandom_range(60, 200);
    bus_wr(4'h1, 16'(g));
    bus_wr(4'h0, 16'h0003);
    wait_done(400, lat);
    check("post_abort_lat", lat, g + 1, 0);
    @(negedge opb_clk);
    bus_rd(4'h8, rd); check("post_abort_res0", rd, g / 8, 1);
    bus_rd(4'hA, rd); check("post_abort_res2", rd, g / 16, 1);
    bus_rd(4'h3, rd); check("post_abort_seq", 32'(rd[7:0]), 2, 0);

    // ---------------- OPB_CLK/4 input
    mon_per[3] = 4;
    bus_wr(4'h1, 16'd4000);
    bus_wr(4'h0, 16'h0003);
    wait_done(4100, lat);
    check("f4_lat", lat, 4001, 0);
    @(negedge opb_clk);
    bus_rd(4'hB, rd); check("f4_res3", rd, 1000, 1);

    // ---------------- GATE = 0 never measures
    bus_wr(4'h1, 16'd0);
    d0 = done_cnt;
    bus_wr(4'h0, 16'h0001);
    repeat (300) @(negedge opb_clk);
    check("gate0_nodone", done_cnt - d0, 0, 0);
    bus_wr(4'h0, 16'h0000);

`ifdef CLK_FREQ_MON_IRQ_EN
    // ---------------- interrupt
    mon_per[0] = 0;
    bus_wr(4'h4, 16'h0001);
    bus_wr(4'h1, 16'd100);
    bus_wr(4'h0, 16'h0001);
    wait_done(300, lat);
    repeat (2) @(negedge opb_clk);
    check("irq_set", 32'(irq), 1, 0);
    bus_wr(4'h3, 16'h0100);
    @(negedge opb_clk);
    check("irq_clr", 32'(irq), 0, 0);
    bus_wr(4'h0, 16'h0000);
    mon_per[0] = 8;
`endif

    // ---------------- counter ceiling with the edge detector stuck high
    force dut.edge_p2 = '1;
    bus_wr(4'h1, 16'hFFFF);
    bus_wr(4'h0, 16'h0003);
    wait_done(66000, lat);
    check("sat_lat", lat, 65536, 0);
    release dut.edge_p2;
    @(negedge opb_clk);
    for (int c = 0; c < NCH; c++) begin
      bus_rd(4'(8 + c), rd);
      check($sformatf("sat_res%0d", c), rd, 32'hFFFF, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
